fact_accel_mmio: RTL and testbench

Memory-mapped iterative factorial accelerator on the data-memory side of the pipeline. It consumes the MEM-stage bus: the write-enable, the ALU result used as the address, and the store data. It returns read data that the MEM/WB register captures as load data. The system address decoder selects it; this block decodes only its four word registers.

---
 rtl/fact_accel_mmio.sv | 173 +++++++++++++++++
 tb/tb_fact_accel_mmio.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fact_accel_mmio.sv
// fact_accel_mmio
//   Memory-mapped iterative factorial accelerator on the data-memory side of
//   the pipeline. The system decoder has already qualified WE with this
//   block's select, so only the four word registers are decoded here.
//
//   Register map (word offset = A):
//     0 N      r/w  operand n, zero-extended on read
//     1 GO     r/w  bit 0; writing 1 while not busy starts a computation
//     2 STATUS ro   {0.., busy, err, done}
//     3 RESULT ro   last completed factorial (wraps modulo 2^DATA_WIDTH)
//
//   Ports:
//     CLK        in   clock, rising edge
//     RST        in   asynchronous active-low reset
//     WE         in   write strobe
//     A[1:0]     in   word address (byte address bits [3:2])
//     WD         in   store data
//     RD         out  read data, combinational from A (zero latency)
//     dbg_state  out  current FSM state encoding (IDLE=0, CALC=1, DONE=2)
//
//   Build option: define FACT_ACCEL_OVF_CHECK_EN to reject n > 12 on start
//   (err=1, done=1, result=0, no CALC cycles). Without it, every n is
//   computed and err always reads 0.
//
//   Handshake: there is no valid/ready pair on this bus. A write takes effect
//   on the rising edge where WE=1; a read is the combinational RD for the
//   current A and reflects register contents before that edge.
module fact_accel_mmio #(
    parameter int DATA_WIDTH = 32,
    parameter int N_WIDTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic [1:0]            A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [N_WIDTH-1:0]    n_reg;
    logic                  go_reg;
    logic [N_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] result;
    logic                  done;
    logic                  err;
    logic                  busy;

    logic go_write;
    logic start_req;
    logic ovf_hit;
    logic start_acc;
    logic ovf_start;
    logic calc_step;
    logic calc_done;

    // Only the low N_WIDTH bits of WD are ever stored.
    logic unused_wd;
    assign unused_wd = ^WD[DATA_WIDTH-1:N_WIDTH];

    assign go_write  = WE && (A == 2'd1);
    assign start_req = go_write && WD[0];
    assign busy      = (state == CALC);
    assign dbg_state = state;

`ifdef FACT_ACCEL_OVF_CHECK_EN
    // 13! no longer fits in 32 bits.
    assign ovf_hit = ({{(32-N_WIDTH){1'b0}}, n_reg} > 32'd12);
`else
    assign ovf_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and datapath controls
    always_comb begin
        next_state = state;
        start_acc  = 1'b0;
        ovf_start  = 1'b0;
        calc_step  = 1'b0;
        calc_done  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_req) begin
                    start_acc = 1'b1;
                    if (ovf_hit) begin
                        ovf_start  = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = CALC;
                    end
                end
            end
            CALC: begin
                // A GO write here is ignored by the FSM; the GO bit still
                // updates in the datapath below.
                if (cnt <= N_WIDTH'(1)) begin
                    calc_done  = 1'b1;
                    next_state = DONE;
                end else begin
                    calc_step = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registers and datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            n_reg  <= '0;
            go_reg <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (WE && (A == 2'd0)) begin
                n_reg <= WD[N_WIDTH-1:0];
            end
            if (go_write) begin
                go_reg <= WD[0];
            end
            if (start_acc) begin
                // cnt latches n here, so later N writes cannot disturb CALC.
                cnt  <= n_reg;
                prod <= DATA_WIDTH'(1);
                done <= ovf_start;
                err  <= ovf_start;
                if (ovf_start) begin
                    result <= '0;
                end
            end
            if (calc_step) begin
                prod <= prod * DATA_WIDTH'(cnt);
                cnt  <= cnt - N_WIDTH'(1);
            end
            if (calc_done) begin
                result <= prod;
                done   <= 1'b1;
            end
        end
    end

    // Zero-latency read mux
    always_comb begin
        RD = '0;
        case (A)
            2'd0: RD = DATA_WIDTH'(n_reg);
            2'd1: RD = DATA_WIDTH'(go_reg);
            2'd2: RD = DATA_WIDTH'({busy, err, done});
            2'd3: RD = result;
            default: RD = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel_mmio.sv
// Testbench for fact_accel_mmio: directed register-bus stimulus, a behavioural
// register-map model compared against RD on every falling edge, plus literal
// expectations at key points.
module tb_fact_accel_mmio;

    logic        CLK;
    logic        RST;
    logic        WE;
    logic [1:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

`ifdef FACT_ACCEL_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    fact_accel_mmio #(.DATA_WIDTH(32), .N_WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WE        (WE),
        .A         (A),
        .WD        (WD),
        .RD        (RD),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // behavioural model of the register map
    logic [3:0]  m_n;
    logic        m_go;
    logic        m_busy;
    logic        m_done;
    logic        m_err;
    logic [31:0] m_result;
    logic [31:0] m_pend;
    int          m_rem;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_n};
            2'd1:    return {31'd0, m_go};
            2'd2:    return {29'd0, m_busy, m_err, m_done};
            default: return m_result;
        endcase
    endfunction

    task automatic model_reset();
        m_n = 4'd0; m_go = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_err = 1'b0; m_result = 32'd0; m_pend = 32'd0; m_rem = 0;
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] wd);
        logic busy_pre;
        logic [3:0] n_pre;
        busy_pre = m_busy;
        n_pre    = m_n;
        if (m_busy) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_result = m_pend;
                m_done   = 1'b1;
                m_busy   = 1'b0;
            end
        end
        if (we && a == 2'd0) m_n = wd[3:0];
        if (we && a == 2'd1) begin
            m_go = wd[0];
            if (wd[0] && !busy_pre) begin
                m_done = 1'b0;
                m_err  = 1'b0;
                if (OVF_EN && n_pre > 4'd12) begin
                    m_done   = 1'b1;
                    m_err    = 1'b1;
                    m_result = 32'd0;
                end else begin
                    m_busy = 1'b1;
                    m_rem  = (n_pre == 4'd0) ? 1 : int'(n_pre);
                    m_pend = fact(int'(n_pre));
                end
            end
        end
    endtask

    // scoreboard check
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // compare process: RD against the model every falling edge
    always @(negedge CLK) begin
        check("rd_vs_model", RD, model_rd(A));
    end

    // driver tasks
    task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] wd);
        WE = we; A = a; WD = wd;
        @(posedge CLK);
        if (RST) model_edge(we, a, wd);
        #1;
        WE = 1'b0; A = 2'd2; WD = 32'd0;
    endtask

    task automatic start(input logic [3:0] n);
        drive(1'b1, 2'd0, {28'd0, n});
        drive(1'b1, 2'd1, 32'd1);
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (m_busy && b < 40) begin
            drive(1'b0, 2'd2, 32'd0);
            b++;
        end
        if (b >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: busy after %0d cycles, required idle", b);
        end
    endtask

    task automatic peek(input string name, input logic [1:0] a, input logic [31:0] exp);
        A = a;
        #1;
        check(name, RD, exp);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        model_reset();
        RST = 1'b0; WE = 1'b0; A = 2'd0; WD = 32'd0;
        #3;
        for (int a = 0; a < 4; a++) peek("reset_value", 2'(a), 32'd0);
        @(negedge CLK);
        #2 RST = 1'b1;

        // basic n=5
        start(4'd5);
        peek("n5_busy", 2'd2, 32'h4);
        wait_done();
        peek("n5_status", 2'd2, 32'h1);
        peek("n5_result", 2'd3, 32'd120);

        // boundaries
        start(4'd0);
        wait_done();
        peek("n0_result", 2'd3, 32'd1);
        start(4'd1);
        wait_done();
        peek("n1_result", 2'd3, 32'd1);
        start(4'd12);
        wait_done();
        peek("n12_result", 2'd3, 32'h1C8CFC00);

        // ignored restart with N rewritten during CALC
        start(4'd6);
        drive(1'b0, 2'd2, 32'd0);
        drive(1'b1, 2'd0, 32'd3);
        drive(1'b1, 2'd1, 32'd1);
        peek("restart_go_bit", 2'd1, 32'd1);
        peek("restart_n_reg", 2'd0, 32'd3);
        wait_done();
        peek("restart_result", 2'd3, 32'd720);
        drive(1'b1, 2'd1, 32'd0);
        drive(1'b1, 2'd1, 32'd1);
        wait_done();
        peek("fresh_result", 2'd3, 32'd6);

        // n=13
        start(4'd13);
`ifdef FACT_ACCEL_OVF_CHECK_EN
        peek("ovf_status", 2'd2, 32'h3);
        peek("ovf_result", 2'd3, 32'd0);
`else
        wait_done();
        peek("n13_status", 2'd2, 32'h1);
        peek("n13_result", 2'd3, 32'h7328CC00);
`endif

        // n=15 wraps (or is rejected)
        start(4'd15);
        wait_done();

        // read-only offsets ignore writes; N keeps only its low bits
        drive(1'b1, 2'd3, 32'hDEADBEEF);
        drive(1'b1, 2'd2, 32'hFFFFFFFF);
        drive(1'b1, 2'd0, 32'hFFFFFFF7);
        peek("n_low_bits", 2'd0, 32'd7);

        // reset mid-computation
        start(4'd9);
        drive(1'b0, 2'd2, 32'd0);
        drive(1'b0, 2'd2, 32'd0);
        drive(1'b0, 2'd2, 32'd0);
        RST = 1'b0;
        model_reset();
        peek("rst_status", 2'd2, 32'd0);
        peek("rst_result", 2'd3, 32'd0);
        peek("rst_n", 2'd0, 32'd0);
        peek("rst_go", 2'd1, 32'd0);
        @(negedge CLK);
        #2 RST = 1'b1;
        start(4'd3);
        wait_done();
        peek("after_rst_result", 2'd3, 32'd6);

        drive(1'b0, 2'd2, 32'd0);
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
